// File: rtl/s_to_p.sv
// Serial-to-parallel converter: collects DATA_W serial bits (LSB first) under a
// valid/ready handshake and emits each completed word with a one-cycle strobe.
module s_to_p #(
    parameter int unsigned DATA_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_a,
    input  logic              data_a,
    output logic              ready_a,
    output logic              valid_b,
    output logic [DATA_W-1:0] data_b
);

    localparam int unsigned     CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-2:0] shift_q;
    logic              accept_c;
    logic              last_c;
    logic [DATA_W-1:0] word_c;

    // Only DATA_W-1 bits are stored; the final bit is merged in straight from data_a.
    always_comb begin
        accept_c = valid_a && ready_a;
        last_c   = accept_c && (cnt_q == LAST);
        word_c   = {data_a, shift_q};
    end

    // rst_n is active-high and synchronous despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ready_a <= 1'b0;
            valid_b <= 1'b0;
            data_b  <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            ready_a <= 1'b1;
            valid_b <= last_c;
            if (accept_c) begin
                shift_q <= word_c[DATA_W-1:1];
                cnt_q   <= last_c ? '0 : cnt_q + CNT_W'(1);
            end
            if (last_c) begin
                data_b <= word_c;
            end
        end
    end

endmodule

// File: tb/tb_s_to_p.sv
// Self-checking bench for s_to_p: table-driven words plus hand-written corner
// sequences, with a scoreboard queue of expected words popped on each valid_b.
module tb_s_to_p;

    logic       clk;
    logic       rst_n;
    logic       valid_a;
    logic       data_a;
    logic       ready_a;
    logic       valid_b;
    logic [5:0] data_b;

    logic       valid_a8;
    logic       data_a8;
    logic       ready_a8;
    logic       valid_b8;
    logic [7:0] data_b8;

    int errors = 0;
    int checks = 0;
    int pulses8 = 0;
    logic [7:0] last8 = '0;

    logic [5:0] exp_q[$];

    typedef struct {
        logic [5:0]  seq;   // seq[i] is the i-th bit sent
        logic [11:0] gaps;  // gaps[2*i+:2] idle cycles after bit i
        logic [5:0]  exp;
    } vec_t;

    vec_t vecs[4];

    s_to_p #(.DATA_W(6)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_a (valid_a),
        .data_a  (data_a),
        .ready_a (ready_a),
        .valid_b (valid_b),
        .data_b  (data_b)
    );

    s_to_p #(.DATA_W(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_a (valid_a8),
        .data_a  (data_a8),
        .ready_a (ready_a8),
        .valid_b (valid_b8),
        .data_b  (data_b8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (valid_b === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid_b: data_b=%b with no word pending at %0t", data_b, $time);
            end else begin
                check("scoreboard_data_b", 8'(data_b), 8'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b8 === 1'b1) begin
            pulses8++;
            last8 = data_b8;
        end
    end

    task automatic send_bit(input logic b);
        valid_a = 1'b1;
        data_a  = b;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        data_a  = 1'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d word(s) still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{seq: 6'b101000, gaps: 12'b00_00_11_00_01_00, exp: 6'b101000};
        vecs[1] = '{seq: 6'b010110, gaps: 12'b00_00_00_00_00_00, exp: 6'b010110};
        vecs[2] = '{seq: 6'b100001, gaps: 12'b00_01_10_01_11_01, exp: 6'b100001};
        vecs[3] = '{seq: 6'b000000, gaps: 12'b00_00_00_01_00_00, exp: 6'b000000};

        rst_n    = 1'b1;
        valid_a  = 1'b0;
        data_a   = 1'b0;
        valid_a8 = 1'b0;
        data_a8  = 1'b0;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_ready_a", 8'(ready_a), 8'h00);
        check("reset_valid_b", 8'(valid_b), 8'h00);
        check("reset_data_b", 8'(data_b), 8'h00);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("release_ready_a", 8'(ready_a), 8'h01);

        // Table-driven words with assorted gaps
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 6; i++) begin
                if (i == 5) exp_q.push_back(vecs[v].exp);
                send_bit(vecs[v].seq[i]);
                idle(int'(vecs[v].gaps[2*i +: 2]));
            end
            wait_drain("vec_word");
            repeat (2) @(posedge clk);
            @(negedge clk);
            check("vec_hold_data_b", 8'(data_b), 8'(vecs[v].exp));
            check("vec_valid_b_low", 8'(valid_b), 8'h00);
        end

        // Continuous stream: strobes follow accept edges 6 and 12
        for (int k = 0; k < 12; k++) begin
            valid_a = 1'b1;
            data_a  = (k < 6) ? ((k % 2) == 0) : 1'b1;
            if (k == 5)  exp_q.push_back(6'b010101);
            if (k == 11) exp_q.push_back(6'b111111);
            @(posedge clk);
            @(negedge clk);
            check("stream_valid_b", 8'(valid_b), (k == 5 || k == 11) ? 8'h01 : 8'h00);
        end
        valid_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stream_valid_b_end", 8'(valid_b), 8'h00);
        check("stream_data_b", 8'(data_b), 8'h3f);
        wait_drain("stream");

        // Partial word, reset, then a bit offered while not ready, then a full word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_ready_a", 8'(ready_a), 8'h00);
        check("midreset_data_b", 8'(data_b), 8'h00);
        rst_n   = 1'b0;
        valid_a = 1'b1;
        data_a  = 1'b0;
        @(posedge clk);
        #1;
        valid_a = 1'b0;
        check("midreset_ready_a_back", 8'(ready_a), 8'h01);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) exp_q.push_back(6'b111111);
            send_bit(1'b1);
        end
        wait_drain("after_reset");
        check("after_reset_data_b", 8'(data_b), 8'h3f);

        // Idle input with toggling data
        for (int k = 0; k < 20; k++) begin
            valid_a = 1'b0;
            data_a  = ~data_a;
            @(posedge clk);
            @(negedge clk);
            check("idle_valid_b", 8'(valid_b), 8'h00);
        end
        check("idle_data_b", 8'(data_b), 8'h3f);

        // Eight-bit instance: single set bit lands in data_b[0]
        pulses8 = 0;
        check("w8_ready_a", 8'(ready_a8), 8'h01);
        for (int i = 0; i < 8; i++) begin
            valid_a8 = 1'b1;
            data_a8  = (i == 0);
            @(posedge clk);
            #1;
        end
        valid_a8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("w8_pulses", 8'(pulses8), 8'h01);
        check("w8_data_b", last8, 8'h01);
        check("w8_data_b_hold", data_b8, 8'h01);

        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s_to_p.md
Name: s_to_p

Overview:
- Serial-to-parallel converter: accepts a 1-bit serial stream under a valid/ready handshake and assembles it into 6-bit words.
- Each completed word is presented on a parallel output with a one-cycle valid strobe.
- Sits between a bit-serial producer and a word-wide consumer; the output side has no backpressure.

Parameters:
- DATA_W, 6, number of serial bits per parallel word (must be >= 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-high despite the _n suffix: sampled on the clk rising edge, reset takes effect when rst_n==1.
- valid_a  input  1  upstream bit valid.
- data_a  input  1  upstream serial data bit.
- ready_a  output  1  block can accept a bit this cycle.
- valid_b  output  1  one-cycle strobe: data_b holds a newly completed word.
- data_b  output  DATA_W  assembled parallel word.

Behaviour:
- Single clock domain; all outputs registered; no combinational input-to-output paths.
- Reset (rst_n==1 at a clk edge):
  - ready_a=0, valid_b=0, data_b=0.
  - Bit counter and shift register cleared.
  - Reset applied mid-word discards the partial word.
- ready_a:
  - Goes to 1 on the first clk edge with reset deasserted.
  - Stays 1 permanently afterwards; the block never stalls.
- Accept condition: valid_a && ready_a at a rising edge. One bit is accepted per such edge.
- Cycles with valid_a=0 are gaps. Counter and shift register hold; gaps of any length are allowed mid-word.
- Bit order is LSB first:
  - The first accepted bit of a word lands in data_b[0]; the DATA_W-th bit lands in data_b[DATA_W-1].
  - Implementation: shift register updated as shift <= {data_a, shift[DATA_W-1:1]} on each accept.
- Counter runs 0..DATA_W-1:
  - Increments on each accept.
  - On the accept where counter==DATA_W-1: the counter wraps to 0, and data_b loads the full word, i.e. {data_a, shift[DATA_W-1:1]}.
  - valid_b=1 for exactly the following cycle (latency 1 clock from the last bit's accept edge).
- valid_b:
  - Deasserts on the next edge unless another word completes on that edge.
  - Back-to-back words (DATA_W continuous accepts) give one valid_b pulse every DATA_W cycles.
- data_b:
  - Holds its value until the next completed word or reset.
  - Partial words never alter data_b.
- Simultaneous events:
  - A bit accepted in the same cycle valid_b is high counts as bit 0 of the next word.
  - Reset has priority over accept.
- data_a is ignored when valid_a=0.

Test Plan:
- Reset: hold rst_n=1 for 5 cycles -> ready_a=0, valid_b=0, data_b=000000. Release -> ready_a=1 on the next edge.
- Gapped word: accept bits 0,0,0,1,0,1 in that order, with valid_a gaps of 1 and 3 cycles between some bits -> after the 6th accept, data_b=101000 and valid_b high for exactly 1 cycle; data_b still 101000 two cycles later.
- Continuous stream: 12 consecutive accepts of 1,0,1,0,1,0, then 1,1,1,1,1,1 -> valid_b pulses at cycles 7 and 13 (relative to first accept edge = 1); data_b=010101, then 111111.
- Partial word then reset: accept 3 bits, assert reset 1 cycle, then accept 6 bits of 1 -> exactly one valid_b pulse, data_b=111111, with no contribution from the pre-reset bits.
- Idle input: valid_a=0 with data_a toggling for 20 cycles -> no valid_b, data_b unchanged.
- Parameter check: DATA_W=8, bits 1,0,0,0,0,0,0,0 -> data_b=00000001 with one valid_b pulse.
